// File: rtl/lut_neuron_programmer.sv
// Runtime-programmable LogicNets neuron: streams a truth table into a shadow buffer,
// commits it atomically to the active table, and serves registered lookups.
module lut_neuron_programmer #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int WORD_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic                table_valid,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int TABLE_BITS = (2 ** IN_BITS) * OUT_BITS;
  localparam int WORDS      = (TABLE_BITS + WORD_W - 1) / WORD_W;
  localparam int CNT_W      = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [WORDS*WORD_W-1:0]  shadow_q, shadow_d;
  logic [TABLE_BITS-1:0]    active_q, active_d;
  logic                     table_valid_q, table_valid_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0]      out_data_q, out_data_d;
  logic                     accept;

  assign cfg_ready   = !rst && (state_q != ST_COMMIT);
  assign accept      = cfg_valid && cfg_ready;
  assign cfg_done    = (state_q == ST_COMMIT);
  assign cfg_err     = cfg_err_q;
  assign table_valid = table_valid_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    table_valid_d = table_valid_q;
    cfg_err_d     = cfg_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shadow_d[WORD_W-1:0] = cfg_data;
          cnt_d     = CNT_W'(1);
          cfg_err_d = 1'b0;
          if (cfg_last) begin
            if (WORDS == 1) begin
              state_d = ST_COMMIT;
            end else begin
              cfg_err_d = 1'b1;
            end
          end else begin
            state_d = (WORDS == 1) ? ST_DRAIN : ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          shadow_d[cnt_q*WORD_W +: WORD_W] = cfg_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = cfg_last ? ST_COMMIT : ST_DRAIN;
          end else if (cfg_last) begin
            state_d   = ST_IDLE;
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Overlong load: swallow words until the terminator, then flag it.
        if (accept && cfg_last) begin
          state_d   = ST_IDLE;
          cfg_err_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        active_d      = shadow_q[TABLE_BITS-1:0];
        table_valid_d = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = in_valid;
    out_data_d  = table_valid_q ? active_q[in_data*OUT_BITS +: OUT_BITS] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      active_q      <= '0;
      table_valid_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      table_valid_q <= table_valid_d;
      cfg_err_q     <= cfg_err_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
    end
  end

  // Shadow buffer carries no reset; its contents only matter after a full load.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

endmodule

// File: tb/tb_lut_neuron_programmer.sv
// Self-checking bench for lut_neuron_programmer: table-driven lookups checked through
// a scoreboard queue, plus hand-written load, commit-boundary and reset sequences.
module tb_lut_neuron_programmer;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       cfg_done;
  logic       cfg_err;
  logic       table_valid;
  logic       in_valid;
  logic [5:0] in_data;
  logic       out_valid;
  logic [0:0] out_data;

  typedef struct {
    logic [5:0] addr;
    logic       exp;
  } vec_t;

  vec_t       vecs_a [7];
  vec_t       vecs_b [7];
  logic [7:0] cfg_words [16];
  logic       exp_q [$];
  int         checks;
  int         failures;

  lut_neuron_programmer dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .cfg_last    (cfg_last),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .table_valid (table_valid),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: out_valid must mirror the previous cycle's in_valid, and each
  // valid result is compared with the expectation queued when the lookup was driven.
  initial begin
    logic exp_valid;
    logic exp_data;
    forever begin
      @(posedge clk);
      exp_valid = rst ? 1'b0 : in_valid;
      #1;
      checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          exp_data = exp_q.pop_front();
          checkOutput("out_data", 32'(out_data), 32'(exp_data));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [5:0] addr, input logic exp);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = addr;
    exp_q.push_back(exp);
  endtask

  task automatic runVectors(input bit use_b);
    vec_t v;
    for (int i = 0; i < 7; i++) begin
      v = use_b ? vecs_b[i] : vecs_a[i];
      applyStimulus(v.addr, v.exp);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic loadTable(input int n, input bit expect_commit);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 1) checkOutput("err_cleared_first_word", 32'(cfg_err), 32'd0);
      checkOutput("ready_during_load", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b1;
      cfg_data  = cfg_words[i];
      cfg_last  = (i == n - 1);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    if (expect_commit) begin
      checkOutput("commit_done", 32'(cfg_done), 32'd1);
      checkOutput("commit_ready", 32'(cfg_ready), 32'd0);
      @(negedge clk);
      checkOutput("post_commit_done", 32'(cfg_done), 32'd0);
      checkOutput("post_commit_ready", 32'(cfg_ready), 32'd1);
      checkOutput("post_commit_table_valid", 32'(table_valid), 32'd1);
      checkOutput("post_commit_err", 32'(cfg_err), 32'd0);
    end else begin
      checkOutput("bad_load_err", 32'(cfg_err), 32'd1);
      checkOutput("bad_load_done", 32'(cfg_done), 32'd0);
      checkOutput("bad_load_ready", 32'(cfg_ready), 32'd1);
      @(negedge clk);
      checkOutput("bad_load_no_done", 32'(cfg_done), 32'd0);
    end
  endtask

  task automatic setTableA();
    for (int i = 0; i < 16; i++) cfg_words[i] = 8'h00;
    cfg_words[0] = 8'hA5;
    cfg_words[7] = 8'h80;
  endtask

  initial begin
    vecs_a[0] = '{6'd0, 1'b1};   vecs_b[0] = '{6'd0, 1'b0};
    vecs_a[1] = '{6'd1, 1'b0};   vecs_b[1] = '{6'd1, 1'b0};
    vecs_a[2] = '{6'd2, 1'b1};   vecs_b[2] = '{6'd2, 1'b1};
    vecs_a[3] = '{6'd5, 1'b1};   vecs_b[3] = '{6'd5, 1'b1};
    vecs_a[4] = '{6'd6, 1'b0};   vecs_b[4] = '{6'd6, 1'b0};
    vecs_a[5] = '{6'd63, 1'b1};  vecs_b[5] = '{6'd63, 1'b1};
    vecs_a[6] = '{6'd62, 1'b0};  vecs_b[6] = '{6'd62, 1'b0};
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    cfg_last  = 1'b0;
    in_valid  = 1'b0;
    in_data   = 6'd0;

    // Reset, then a lookup into the never-loaded table.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(cfg_ready), 32'd0);
    checkOutput("rst_done", 32'(cfg_done), 32'd0);
    checkOutput("rst_err", 32'(cfg_err), 32'd0);
    checkOutput("rst_table_valid", 32'(table_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(cfg_ready), 32'd1);
    applyStimulus(6'h15, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("unloaded_table_valid", 32'(table_valid), 32'd0);
    @(negedge clk);

    // Full correct load, then table-driven lookups.
    setTableA();
    loadTable(8, 1'b1);
    runVectors(1'b0);

    // Short load: error, old table kept.
    for (int i = 0; i < 16; i++) cfg_words[i] = 8'h5A;
    loadTable(5, 1'b0);
    runVectors(1'b0);

    // Long load: drains past word 8, error, old table kept.
    for (int i = 0; i < 16; i++) cfg_words[i] = 8'hFF;
    loadTable(10, 1'b0);
    checkOutput("long_err_sticky", 32'(cfg_err), 32'd1);
    runVectors(1'b0);

    // Correct load streamed against lookups at address 0 every cycle: entry 0
    // flips 1->0; lookups sampled up to the COMMIT-ending edge still see 1.
    setTableA();
    cfg_words[0] = 8'hA4;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 1) checkOutput("stream_err_cleared", 32'(cfg_err), 32'd0);
      if (c == 8) checkOutput("stream_commit_done", 32'(cfg_done), 32'd1);
      if (c < 8) begin
        cfg_valid = 1'b1;
        cfg_data  = cfg_words[c];
        cfg_last  = (c == 7);
      end else begin
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = 6'd0;
      exp_q.push_back((c <= 8) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    runVectors(1'b1);

    // Reset in the middle of a load.
    setTableA();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data  = 8'hFF;
      cfg_last  = 1'b0;
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready", 32'(cfg_ready), 32'd0);
    checkOutput("midrst_table_valid", 32'(table_valid), 32'd0);
    checkOutput("midrst_err", 32'(cfg_err), 32'd0);
    checkOutput("midrst_done", 32'(cfg_done), 32'd0);
    checkOutput("midrst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(6'd0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    loadTable(8, 1'b1);
    runVectors(1'b0);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lut_neuron_programmer.md
# lut_neuron_programmer

Runtime-programmable LogicNets neuron: the writer side for the fixed truth-table neurons. It accepts a truth table as a byte stream, stores it in a shadow buffer, and commits it atomically to an active table. The active table serves pipelined lookups. It sits between the host configuration bus and each neuron slot in a layer, so a layer can be retrained and reloaded without resynthesis.

## Interface
- IN_BITS, 6, neuron fan-in bits (table address width)
- OUT_BITS, 1, neuron output width per entry
- WORD_W, 8, configuration word width
- Derived: TABLE_BITS = (2**IN_BITS)*OUT_BITS (64); WORDS = ceil(TABLE_BITS/WORD_W) (8)

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config word present
- cfg_ready  out  1  programmer accepts word this cycle
- cfg_data  in  WORD_W  config word
- cfg_last  in  1  marks final word of a table load
- cfg_done  out  1  one-cycle pulse when a table commits
- cfg_err  out  1  sticky: last load had the wrong word count
- table_valid  out  1  active table has been loaded at least once since reset
- in_valid  in  1  lookup request
- in_data  in  IN_BITS  lookup address (neuron input vector)
- out_valid  out  1  lookup result valid
- out_data  out  OUT_BITS  table entry

## Operation
- Bit mapping: word k, bit j → table bit k*WORD_W+j. Entry a = table bits [a*OUT_BITS +: OUT_BITS]. Bits beyond TABLE_BITS in the last word are ignored.
- A word is accepted when cfg_valid && cfg_ready.
- FSM states: IDLE, LOAD, DRAIN, COMMIT.
  - IDLE: cfg_ready=1. On an accepted word: write to shadow[0], cnt=1, clear cfg_err. If cfg_last is also high, go to IDLE and set cfg_err (unless WORDS==1, then go to COMMIT). Otherwise go to LOAD.
  - LOAD: cfg_ready=1. Each accepted word is written to shadow[cnt] and cnt increments.
    - Accepted with cfg_last and cnt+1==WORDS → COMMIT.
    - Accepted with cfg_last and cnt+1<WORDS → IDLE, set cfg_err; active table unchanged.
    - Accepted without cfg_last and cnt+1==WORDS → DRAIN.
  - DRAIN: cfg_ready=1. Accepted words are discarded. An accepted word with cfg_last → IDLE, set cfg_err. A word with cfg_last is the required terminator; a WORDS-word load is valid only if the last word carries cfg_last.
  - COMMIT: cfg_ready=0 for exactly one cycle. Active table ← shadow; table_valid←1; cfg_done=1 during this cycle. Next state is IDLE.
- Lookup: out_data ← active[in_data], out_valid ← in_valid, registered. If table_valid=0, out_data=0. Lookups are accepted every cycle in all FSM states; loading never stalls lookups.
- Active table reset value: all zeros. Shadow buffer is not reset.

## Timing
- Reset values: cfg_ready=0 during rst, 1 from the first cycle after. cfg_done=0, cfg_err=0, table_valid=0, out_valid=0, out_data=0. FSM=IDLE, cnt=0.
- Lookup latency: 1 cycle. out_* are registered, with full throughput.
- Commit boundary:
  - A lookup sampled at the edge that ends COMMIT uses the old table.
  - A lookup sampled one edge later uses the new table.
- Minimum load time is WORDS+1 cycles (WORDS accept cycles plus COMMIT); the next load can start the cycle after COMMIT.
- Reset mid-load discards the shadow contents and the count. The active table and table_valid return to reset values because reset clears everything.
- cfg_err persists until the first word of the next load is accepted, or until rst.

## Test plan
- Reset then lookup: hold rst 2 cycles, then send in_data=0x15 with in_valid → one cycle later out_valid=1, out_data=0, table_valid=0, cfg_ready=1.
- Full load: words 0xA5,0x00,0x00,0x00,0x00,0x00,0x00,0x80 (last on 8th) → COMMIT pulses cfg_done, cfg_ready=0 for 1 cycle, table_valid=1. Lookups give 0→1, 1→0, 2→1, 5→1, 6→0, 63→1, 62→0.
- Short load: 5 words with cfg_last on the 5th → cfg_err=1, no cfg_done, lookups still return the previous table.
- Long load: 10 words with cfg_last on the 10th → DRAIN entered after word 8, cfg_err=1, active table unchanged. A following correct load clears cfg_err on its first word and commits.
- Lookup across commit: stream lookups at address 0 every cycle while loading a table flipping entry 0 from 1 to 0. Results stay 1 through the lookup sampled at the COMMIT edge, then read 0, with no bubble in out_valid.
- Reset mid-load: assert rst after 4 of 8 words → all outputs at reset values. A subsequent full 8-word load commits normally with correct contents.
